// File: rtl/bus_pkg.sv
// Shared definitions for the femtorv32 N-slave bus decoder: FSM encodings,
// default error read data and the standard mem/leds/uart/timer windows.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_ERR  = 2'd2
  } bus_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] LEDS_BASE   = 32'h1000_0000;
  localparam logic [31:0] UART_BASE   = 32'h2000_0000;
  localparam logic [31:0] TIMER_BASE  = 32'h4000_0000;
  localparam logic [31:0] WINDOW_MASK = 32'hF000_0000;

  localparam logic [127:0] DEFAULT_BASE = {TIMER_BASE, UART_BASE, LEDS_BASE, MEM_BASE};
  localparam logic [127:0] DEFAULT_MASK = {4{WINDOW_MASK}};

  // Index width that stays legal for a single-slave build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational address matcher: one-hot hit vector (lowest index wins on
// overlapping windows), encoded index of the winner, and an any-hit flag.
module bus_addr_match
  import bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = DEFAULT_BASE,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = DEFAULT_MASK,
  localparam int                      IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]           i_addr,
  output logic [NUM_SLAVES-1:0] o_hit,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_any_hit
);

  logic [NUM_SLAVES-1:0] w_raw_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_cmp
      assign w_raw_hit[gi] = ((i_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32]);
    end
  endgenerate

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    o_hit = '0;
    o_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_raw_hit[i]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_idx    = IDX_W'(i);
      end
    end
  end

  assign o_any_hit = |w_raw_hit;

endmodule

// File: rtl/bus_decoder_n.sv
// N-slave address decoder and read-data router for the femtorv32 bus.
// Optional read watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_decoder_n
  import bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = DEFAULT_BASE,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = DEFAULT_MASK,
  parameter logic [31:0]              ERR_RDATA  = ERR_RDATA_DEFAULT,
`ifdef BUS_TIMEOUT_EN
  parameter int                       TIMEOUT_CYCLES = 255,
`endif
  localparam int                      IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             m_addr,
  input  logic                    m_rstrb,
  input  logic [3:0]              m_wmask,
  output logic [31:0]             m_rdata,
  output logic                    m_rbusy,
  output logic                    m_wbusy,
  output logic [NUM_SLAVES-1:0]   s_rstrb,
  output logic [4*NUM_SLAVES-1:0] s_wmask,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]   s_rbusy,
  input  logic [NUM_SLAVES-1:0]   s_wbusy,
  input  logic                    err_clr,
  output logic                    err_flag,
  output logic [31:0]             err_addr
);

  logic [NUM_SLAVES-1:0] w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any_hit;
  logic                  w_rd_accept;
  logic                  w_wr;
  logic                  w_unmapped;
  bus_state_t            r_state;
  bus_state_t            w_state_next;
  logic [IDX_W-1:0]      r_rd_idx;

  bus_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .i_addr    (m_addr),
    .o_hit     (w_hit),
    .o_idx     (w_idx),
    .o_any_hit (w_any_hit)
  );

  assign w_rd_accept = m_rstrb && (r_state == ST_IDLE);
  assign w_wr        = |m_wmask;
  assign w_unmapped  = !w_any_hit && (w_rd_accept || w_wr);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_fwd
      assign s_rstrb[gi]        = w_rd_accept && w_hit[gi];
      assign s_wmask[4*gi +: 4] = w_hit[gi] ? m_wmask : 4'b0000;
    end
  endgenerate

  assign m_wbusy = w_wr && |(s_wbusy & w_hit);
  assign m_rbusy = (r_state == ST_RD_WAIT) && s_rbusy[r_rd_idx];
  assign m_rdata = (r_state == ST_RD_ERR) ? ERR_RDATA : s_rdata[32*r_rd_idx +: 32];

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic [31:0]      r_rd_addr;
  logic             w_timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt  <= '0;
      r_rd_addr <= '0;
    end else if (w_rd_accept && w_any_hit) begin
      r_to_cnt  <= '0;
      r_rd_addr <= m_addr;
    end else if (r_state == ST_RD_WAIT) begin
      r_to_cnt  <= r_to_cnt + CNT_W'(1);
    end
  end

  // Fires on the last of TIMEOUT_CYCLES wait cycles if the slave is still busy.
  assign w_timeout = (r_state == ST_RD_WAIT) && s_rbusy[r_rd_idx] &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m_rstrb) w_state_next = w_any_hit ? ST_RD_WAIT : ST_RD_ERR;
      end
      ST_RD_WAIT: begin
        if (!s_rbusy[r_rd_idx]) w_state_next = ST_IDLE;
`ifdef BUS_TIMEOUT_EN
        else if (w_timeout) w_state_next = ST_RD_ERR;
`endif
      end
      ST_RD_ERR: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_rd_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rd_accept && w_any_hit) r_rd_idx <= w_idx;
    end
  end

  // Only the first error since the last clear is captured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end else if (!err_flag) begin
      if (w_unmapped) begin
        err_flag <= 1'b1;
        err_addr <= m_addr;
      end
`ifdef BUS_TIMEOUT_EN
      else if (w_timeout) begin
        err_flag <= 1'b1;
        err_addr <= r_rd_addr;
      end
`endif
    end
  end

endmodule
